// File: rtl/rs_issue_sched_if.sv
// Handshake bundle between dispatch, the RS line array, the issue lanes and rs_issue_sched.
// The scheduler connects through the slave modport; the environment drives the master side.
interface rs_issue_sched_if #(
   parameter int RSLEN = 8,
   parameter int WAYS  = 3
);
   localparam int IDXW = $clog2(RSLEN);

   logic                   squash;
   logic [RSLEN-1:0]       line_busy;
   logic [RSLEN-1:0]       line_ready;
   logic [1:0]             dp_req_cnt;
   logic [WAYS-1:0]        fu_ready;
   logic [RSLEN-1:0]       line_enable;
   logic [WAYS-1:0]        alloc_valid;
   logic [WAYS*IDXW-1:0]   alloc_idx;
   logic [WAYS-1:0]        issue_valid;
   logic [WAYS*IDXW-1:0]   issue_idx;
   logic [RSLEN-1:0]       line_clear;
   logic [IDXW:0]          free_cnt;
   logic                   rs_full;

   modport master (
      output squash, line_busy, line_ready, dp_req_cnt, fu_ready,
      input  line_enable, alloc_valid, alloc_idx, issue_valid, issue_idx,
             line_clear, free_cnt, rs_full
   );

   modport slave (
      input  squash, line_busy, line_ready, dp_req_cnt, fu_ready,
      output line_enable, alloc_valid, alloc_idx, issue_valid, issue_idx,
             line_clear, free_cnt, rs_full
   );
endinterface

// File: rtl/rs_issue_sched.sv
// Reservation-station sequencer: lowest-index allocation, round-robin issue with one-cycle grant latency.
// Define RS_STARVE_GUARD_EN to add per-line wait counters that give long-waiting lines priority.
module rs_issue_sched #(
   parameter int RSLEN        = 8,
   parameter int WAYS         = 3,
   parameter int STARVE_LIMIT = 15
) (
   input logic             clock,
   input logic             reset,
   rs_issue_sched_if.slave bus
);
   localparam int IDXW = $clog2(RSLEN);
   localparam int CNTW = IDXW + 1;

   if (RSLEN < 4 || (RSLEN & (RSLEN - 1)) != 0) begin : g_chk_rslen
      $error("rs_issue_sched: RSLEN must be a power of 2 and at least 4");
   end
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_chk_limit
      $error("rs_issue_sched: STARVE_LIMIT must fit the 4-bit wait counter");
   end

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
   // Grant mask of the previous cycle: it is both the clear pulse and the pending set.
   logic [RSLEN-1:0]     grant_q, grant_d;
   logic [WAYS-1:0]      iss_vld_q, iss_vld_d;
   logic [WAYS*IDXW-1:0] iss_idx_q, iss_idx_d;

   logic [CNTW-1:0]      free_cnt;
   logic [RSLEN-1:0]     cand, avail, line_clr;
   logic [IDXW-1:0]      pick, idx, last;
   logic                 found;
   int                   n_req, n_alloc, g;

`ifdef RS_STARVE_GUARD_EN
   logic [3:0]           wait_q [RSLEN];
   logic [3:0]           wait_d [RSLEN];
   logic [RSLEN-1:0]     starved;

   always_comb begin
      for (int i = 0; i < RSLEN; i++) starved[i] = (wait_q[i] >= 4'(STARVE_LIMIT));
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (bus.squash) state_d = FLUSH;
         FLUSH:   state_d = bus.squash ? FLUSH : RUN;
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      free_cnt = '0;
      for (int i = 0; i < RSLEN; i++) free_cnt = free_cnt + CNTW'(!bus.line_busy[i]);
   end

   always_comb begin
      bus.line_enable = '0;
      bus.alloc_valid = '0;
      bus.alloc_idx   = '0;
      n_req           = (int'(bus.dp_req_cnt) > WAYS) ? WAYS : int'(bus.dp_req_cnt);
      n_alloc         = (n_req > int'(free_cnt)) ? int'(free_cnt) : n_req;
      g               = 0;
      if (reset && state_q == RUN && !bus.squash) begin
         for (int i = 0; i < RSLEN; i++) begin
            if (!bus.line_busy[i] && g < n_alloc) begin
               bus.line_enable[i]            = 1'b1;
               bus.alloc_valid[g]            = 1'b1;
               bus.alloc_idx[g*IDXW +: IDXW] = IDXW'(i);
               g                             = g + 1;
            end
         end
      end
   end

   // Lanes are served in ascending order; each takes the next candidate in scan order.
   always_comb begin
      cand      = bus.line_busy & bus.line_ready & ~grant_q;
      avail     = cand;
      grant_d   = '0;
      iss_vld_d = '0;
      iss_idx_d = '0;
      last      = rr_ptr_q;
      found     = 1'b0;
      pick      = '0;
      idx       = '0;
      if (state_q == RUN && !bus.squash) begin
         for (int k = 0; k < WAYS; k++) begin
            found = 1'b0;
            pick  = '0;
            if (bus.fu_ready[k]) begin
`ifdef RS_STARVE_GUARD_EN
               for (int i = 0; i < RSLEN; i++) begin
                  if (!found && avail[i] && starved[i]) begin
                     found = 1'b1;
                     pick  = IDXW'(i);
                  end
               end
`endif
               for (int j = 0; j < RSLEN; j++) begin
                  idx = rr_ptr_q + IDXW'(j);
                  if (!found && avail[idx]) begin
                     found = 1'b1;
                     pick  = idx;
                  end
               end
               if (found) begin
                  avail[pick]                   = 1'b0;
                  grant_d[pick]                 = 1'b1;
                  iss_vld_d[k]                  = 1'b1;
                  iss_idx_d[k*IDXW +: IDXW]     = pick;
                  last                          = pick;
               end
            end
         end
      end
      if (bus.squash || state_q == FLUSH) rr_ptr_d = '0;
      else if (|grant_d)                  rr_ptr_d = last + 1'b1;
      else                                rr_ptr_d = rr_ptr_q;
   end

`ifdef RS_STARVE_GUARD_EN
   always_comb begin
      for (int i = 0; i < RSLEN; i++) begin
         if (state_q == FLUSH || bus.squash || grant_d[i] || line_clr[i]) wait_d[i] = '0;
         else if (cand[i] && wait_q[i] != 4'hF)                           wait_d[i] = wait_q[i] + 4'd1;
         else                                                              wait_d[i] = wait_q[i];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) for (int i = 0; i < RSLEN; i++) wait_q[i] <= '0;
      else        for (int i = 0; i < RSLEN; i++) wait_q[i] <= wait_d[i];
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         iss_vld_q <= '0;
         iss_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         grant_q   <= grant_d;
         iss_vld_q <= iss_vld_d;
         iss_idx_q <= iss_idx_d;
      end
   end

   assign line_clr        = grant_q | {RSLEN{state_q == FLUSH}};
   assign bus.line_clear  = line_clr;
   assign bus.issue_valid = iss_vld_q;
   assign bus.issue_idx   = iss_idx_q;
   assign bus.free_cnt    = free_cnt;
   assign bus.rs_full     = (int'(free_cnt) < WAYS);
endmodule
